hapara_axis_barrier_gen: RTL and testbench
==========================================

# hapara_axis_barrier_gen

Parametrised hardware barrier for up to 32 AXI-Stream masters, typically slave cores or hardware threads. Each master announces arrival by holding tvalid. When every participant in a runtime-programmable mask has arrived, the block releases all of them in the same cycle. It also keeps a generation counter, checks that all participants presented the same barrier ID, and optionally times out stalled barriers.

## Interface
Parameters:
- NUM_SLAVES, 4: number of master channels, 1..32.
- DATA_WIDTH, 32: per-channel tdata width, which carries the barrier ID.
- GEN_WIDTH, 8: generation counter width.
- TIMEOUT_CYCLES, 1024: GATHER timeout, ≥2. Used only with the timeout macro.

Ports:
- m00_axis_aclk  in  1  clock; all logic on rising edge.
- m00_axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  NUM_SLAVES  arrival request per channel.
- s_axis_tdata  in  NUM_SLAVES*DATA_WIDTH  barrier ID; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tready  out  NUM_SLAVES  release, registered.
- cfg_mask  in  NUM_SLAVES  participant mask.
- cfg_mask_wr  in  1  load cfg_mask; accepted only when cfg_busy=0.
- cfg_busy  out  1  high when state≠IDLE or any masked tvalid is high.
- arrived  out  NUM_SLAVES  registered tvalid & mask.
- generation  out  GEN_WIDTH  completed-barrier count.
- release_pulse  out  1  high for the RELEASE cycle.
- err_mismatch  out  1  sticky: ID disagreement at release.
- err_timeout  out  1  sticky: timeout release occurred.
- err_clr  in  1  clears both error flags.

## Operation
- Participant set P = mask. Define syn = (mask≠0) & &(s_axis_tvalid | ~mask).
- States:
  - IDLE: no masked tvalid high.
  - GATHER: ≥1 masked arrival, not syn.
  - RELEASE: exactly one cycle.
- Transitions:
  - IDLE→GATHER when any masked tvalid is high and syn=0.
  - IDLE/GATHER→RELEASE when syn=1.
  - GATHER→IDLE when all masked tvalid drop. This is a protocol violation, with no flag and no generation change.
  - RELEASE→IDLE unconditionally.
- s_axis_tready[i] = 1 only in RELEASE and only for i in the release set. The release set is the mask, or the arrived set on timeout. AXIS rules hold tvalid, so each participant's handshake completes at the end of RELEASE.
- Unmasked channels: tready stays 0 permanently; their tvalid and tdata are ignored.
- On entering RELEASE:
  - Compare tdata of every released channel against the lowest-indexed released channel.
  - Any difference sets err_mismatch.
- On leaving RELEASE: generation increments, wrapping modulo 2^GEN_WIDTH.
- Error flags: err_clr clears them; a set in the same cycle wins over err_clr.
- mask = 0: syn is never true, so the block stays IDLE permanently and cfg_busy=0.
- cfg_mask_wr while cfg_busy=1 is ignored, and mask holds.
- Participant tvalid still high after RELEASE is treated as a new barrier.

## Timing
- Reset values:
  - state IDLE
  - s_axis_tready 0, arrived 0
  - generation 0, release_pulse 0
  - err_mismatch 0, err_timeout 0, cfg_busy 0
  - mask all-ones
- Latency: the last arrival is sampled high at edge k; RELEASE and tready run from edge k to k+1; generation updates at k+1.
- A barrier where all participants arrive at once: tready rises 1 edge after tvalid.
- Minimum barrier period: 2 cycles (RELEASE, IDLE).
- mask updates 1 edge after an accepted cfg_mask_wr.
- arrived lags tvalid by 1 cycle.
- Reset asserted mid-operation: immediate return to reset values; any in-flight barrier is abandoned without a handshake.

## Configuration
- Macro: HAPARA_BARRIER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GATHER and increments each GATHER cycle.
  - When it reaches TIMEOUT_CYCLES-1 with syn=0, the block enters RELEASE with release set = arrived participants only.
  - It sets err_timeout, and generation still increments.
  - syn in the same cycle takes priority and no error is flagged.
- Undefined: no counter; GATHER waits indefinitely; err_timeout is tied to 0.

## Test plan
- NUM_SLAVES=4, mask=4'hF:
  - Stimulus: tvalid rises at cycles 3, 5, 6, 9, all with tdata=7.
  - Response: tready=4'hF only in cycle 10; generation 0→1; err_mismatch=0.
- mask=4'b0101:
  - Stimulus: ch0 and ch2 assert.
  - Response: release with tready=4'b0101; ch1 and ch3 tready stay 0 even with tvalid high.
- Mismatched IDs:
  - Stimulus: tdata ch0=5, ch1=6, all arrive.
  - Response: release occurs and err_mismatch=1. After err_clr it reads 0.
- cfg_mask_wr=4'h3 during GATHER:
  - Response: ignored, mask stays 4'hF.
  - The same write in IDLE loads, and generation wraps 255→0 over 256 barriers with GEN_WIDTH=8.
- With HAPARA_BARRIER_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stimulus: only ch0 arrives.
  - Response: after 16 GATHER cycles, tready=4'b0001 and err_timeout=1. Without the macro, no release ever occurs.
- Reset pulsed during GATHER:
  - Response: all outputs return to reset values within the same cycle and mask=4'hF.

Source files
------------

// File: rtl/hapara_axis_barrier_gen.sv
// Hardware barrier for up to 32 AXI-Stream masters with generation count and ID check.
// Optional GATHER timeout enabled by defining HAPARA_BARRIER_TIMEOUT_EN.
module hapara_axis_barrier_gen #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned GEN_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             m00_axis_aclk,
    input  logic                             m00_axis_aresetn,
    input  logic [NUM_SLAVES-1:0]            s_axis_tvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_axis_tdata,
    output logic [NUM_SLAVES-1:0]            s_axis_tready,
    input  logic [NUM_SLAVES-1:0]            cfg_mask,
    input  logic                             cfg_mask_wr,
    output logic                             cfg_busy,
    output logic [NUM_SLAVES-1:0]            arrived,
    output logic [GEN_WIDTH-1:0]             generation,
    output logic                             release_pulse,
    output logic                             err_mismatch,
    output logic                             err_timeout,
    input  logic                             err_clr
);

    typedef enum logic [1:0] {StIdle, StGather, StRelease} state_e;

    state_e                  state_q;
    logic [NUM_SLAVES-1:0]   mask_q;
    logic [NUM_SLAVES-1:0]   tready_q;
    logic [NUM_SLAVES-1:0]   arrived_q;
    logic [GEN_WIDTH-1:0]    gen_q;
    logic                    pulse_q;
    logic                    err_mis_q;

    logic [NUM_SLAVES-1:0]   masked_valid;
    logic                    any_arr;
    logic                    syn;
    logic                    timeout_hit;
    logic [NUM_SLAVES-1:0]   rel_set;
    logic                    id_mismatch;
    logic [DATA_WIDTH-1:0]   ref_id;
    logic                    ref_found;

    assign masked_valid = s_axis_tvalid & mask_q;
    assign any_arr      = |masked_valid;
    assign syn          = (mask_q != '0) && (&(s_axis_tvalid | ~mask_q));
    // Without a full sync the only way into RELEASE is a timeout, which frees arrivals only.
    assign rel_set      = syn ? mask_q : masked_valid;
    assign cfg_busy     = (state_q != StIdle) || any_arr;

    // Every released ID is compared against the lowest-indexed released channel.
    always_comb begin
        ref_id      = '0;
        ref_found   = 1'b0;
        id_mismatch = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (rel_set[i]) begin
                if (!ref_found) begin
                    ref_id    = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    ref_found = 1'b1;
                end else if (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] != ref_id) begin
                    id_mismatch = 1'b1;
                end
            end
        end
    end

`ifdef HAPARA_BARRIER_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;
    logic            err_to_q;

    assign timeout_hit = (state_q == StGather) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_to_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q   <= StIdle;
            mask_q    <= '1;
            tready_q  <= '0;
            arrived_q <= '0;
            gen_q     <= '0;
            pulse_q   <= 1'b0;
            err_mis_q <= 1'b0;
`ifdef HAPARA_BARRIER_TIMEOUT_EN
            cnt_q     <= '0;
            err_to_q  <= 1'b0;
`endif
        end else begin
            tready_q  <= '0;
            pulse_q   <= 1'b0;
            arrived_q <= masked_valid;
            if (err_clr) begin
                err_mis_q <= 1'b0;
`ifdef HAPARA_BARRIER_TIMEOUT_EN
                err_to_q  <= 1'b0;
`endif
            end
            if (cfg_mask_wr && !cfg_busy) begin
                mask_q <= cfg_mask;
            end
            unique case (state_q)
                StIdle: begin
                    if (syn) begin
                        state_q  <= StRelease;
                        tready_q <= rel_set;
                        pulse_q  <= 1'b1;
                        if (id_mismatch) err_mis_q <= 1'b1;
                    end else if (any_arr) begin
                        state_q <= StGather;
`ifdef HAPARA_BARRIER_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                StGather: begin
                    if (syn || timeout_hit) begin
                        state_q  <= StRelease;
                        tready_q <= rel_set;
                        pulse_q  <= 1'b1;
                        if (id_mismatch) err_mis_q <= 1'b1;
`ifdef HAPARA_BARRIER_TIMEOUT_EN
                        if (!syn) err_to_q <= 1'b1;
`endif
                    end else if (!any_arr) begin
                        state_q <= StIdle;
                    end else begin
`ifdef HAPARA_BARRIER_TIMEOUT_EN
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                    gen_q   <= gen_q + GEN_WIDTH'(1);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign arrived       = arrived_q;
    assign generation    = gen_q;
    assign release_pulse = pulse_q;
    assign err_mismatch  = err_mis_q;

endmodule

// File: tb/tb_hapara_axis_barrier_gen.sv
// Directed self-checking bench for hapara_axis_barrier_gen (NUM_SLAVES=4, TIMEOUT_CYCLES=16).
module tb_hapara_axis_barrier_gen;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned GW = 8;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    tvalid;
    logic [NS*DW-1:0] tdata;
    logic [NS-1:0]    tready;
    logic [NS-1:0]    cfg_mask;
    logic             cfg_mask_wr;
    logic             cfg_busy;
    logic [NS-1:0]    arrived;
    logic [GW-1:0]    generation;
    logic             release_pulse;
    logic             err_mismatch;
    logic             err_timeout;
    logic             err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    hapara_axis_barrier_gen #(
        .NUM_SLAVES     (NS),
        .DATA_WIDTH     (DW),
        .GEN_WIDTH      (GW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .s_axis_tvalid    (tvalid),
        .s_axis_tdata     (tdata),
        .s_axis_tready    (tready),
        .cfg_mask         (cfg_mask),
        .cfg_mask_wr      (cfg_mask_wr),
        .cfg_busy         (cfg_busy),
        .arrived          (arrived),
        .generation       (generation),
        .release_pulse    (release_pulse),
        .err_mismatch     (err_mismatch),
        .err_timeout      (err_timeout),
        .err_clr          (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ids(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        tdata = {d, c, b, a};
    endtask

    task automatic write_mask(input logic [NS-1:0] m);
        cfg_mask    = m;
        cfg_mask_wr = 1'b1;
        tick();
        cfg_mask_wr = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        tvalid      = '0;
        tdata       = '0;
        cfg_mask    = '0;
        cfg_mask_wr = 1'b0;
        err_clr     = 1'b0;
        tick();
        tick();
        check("rst_tready", 32'(tready), 32'h0);
        check("rst_arrived", 32'(arrived), 32'h0);
        check("rst_gen", 32'(generation), 32'h0);
        check("rst_pulse", 32'(release_pulse), 32'h0);
        check("rst_errs", {30'h0, err_mismatch, err_timeout}, 32'h0);
        check("rst_busy", 32'(cfg_busy), 32'h0);
        rst_n = 1'b1;

        // Staggered arrivals, mask all-ones.
        set_ids(7, 7, 7, 7);
        tvalid = 4'b0001; tick();
        check("gather_busy", 32'(cfg_busy), 32'h1);
        check("gather_arrived", 32'(arrived), 32'h1);
        tvalid = 4'b0011; tick();
        tvalid = 4'b0111; tick();
        check("gather_no_rel", 32'(tready), 32'h0);
        tvalid = 4'b1111; tick();
        check("rel_tready", 32'(tready), 32'hF);
        check("rel_pulse", 32'(release_pulse), 32'h1);
        check("rel_gen_before", 32'(generation), 32'h0);
        tick();
        tvalid = '0;
        check("post_tready", 32'(tready), 32'h0);
        check("post_gen", 32'(generation), 32'h1);
        check("post_mis", 32'(err_mismatch), 32'h0);

        // Partial mask: unmasked channels never get tready.
        write_mask(4'b0101);
        tvalid = 4'b1111; tick();
        check("m5_tready", 32'(tready), 32'h5);
        check("m5_arrived", 32'(arrived), 32'h5);
        tick();
        tvalid = '0;
        check("m5_gen", 32'(generation), 32'h2);
        check("m5_tready_off", 32'(tready), 32'h0);

        // ID mismatch and sticky-flag clear.
        write_mask(4'hF);
        set_ids(5, 6, 5, 5);
        tvalid = 4'b1111; tick();
        check("mis_tready", 32'(tready), 32'hF);
        check("mis_flag", 32'(err_mismatch), 32'h1);
        tick();
        tvalid = '0;
        tick();
        check("mis_sticky", 32'(err_mismatch), 32'h1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("mis_clr", 32'(err_mismatch), 32'h0);
        set_ids(7, 7, 7, 7);

        // Mask write during GATHER is ignored.
        tvalid = 4'b0001; tick();
        write_mask(4'h3);
        tvalid = 4'b0011; tick();
        check("busy_wr_ignored", 32'(tready), 32'h0);
        tvalid = 4'b1111; tick();
        check("busy_wr_rel", 32'(tready), 32'hF);
        tick();
        tvalid = '0;
        check("gen_4", 32'(generation), 32'h4);

        // Idle write loads; back-to-back barriers wrap the generation counter.
        write_mask(4'h3);
        tvalid = 4'b0011; tick();
        check("m3_tready", 32'(tready), 32'h3);
        tick();
        for (int i = 0; i < 250; i++) begin
            tick();
            tick();
        end
        check("gen_255", 32'(generation), 32'hFF);
        tick();
        tick();
        tvalid = '0;
        check("gen_wrap", 32'(generation), 32'h0);
        tick();

        // Single arrival: timeout release or indefinite wait.
        write_mask(4'hF);
        tvalid = 4'b0001; tick();
        repeat (15) tick();
        check("to_before", 32'(tready), 32'h0);
`ifdef HAPARA_BARRIER_TIMEOUT_EN
        tick();
        check("to_tready", 32'(tready), 32'h1);
        check("to_flag", 32'(err_timeout), 32'h1);
        tick();
        tvalid = '0;
        check("to_gen", 32'(generation), 32'h1);
`else
        repeat (40) tick();
        check("nto_tready", 32'(tready), 32'h0);
        check("nto_flag", 32'(err_timeout), 32'h0);
        tvalid = '0;
        tick();
        check("nto_idle", 32'(cfg_busy), 32'h0);
        check("nto_gen", 32'(generation), 32'h0);
`endif
        tick();

        // Reset during GATHER restores the all-ones mask.
        write_mask(4'h3);
        tvalid = 4'b0001; tick();
        check("pre_rst_arrived", 32'(arrived), 32'h1);
        #2;
        rst_n  = 1'b0;
        tvalid = '0;
        #1;
        check("mrst_tready", 32'(tready), 32'h0);
        check("mrst_arrived", 32'(arrived), 32'h0);
        check("mrst_gen", 32'(generation), 32'h0);
        check("mrst_busy", 32'(cfg_busy), 32'h0);
        check("mrst_errs", {30'h0, err_mismatch, err_timeout}, 32'h0);
        tick();
        rst_n = 1'b1;
        tvalid = 4'b0011; tick();
        check("mrst_mask_f", 32'(tready), 32'h0);
        tvalid = 4'b1111; tick();
        check("mrst_rel", 32'(tready), 32'hF);
        tick();
        tvalid = '0;
        check("mrst_gen1", 32'(generation), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
